// File: rtl/div_unit.sv
// div_unit: 32-bit iterative restoring divider for signed/unsigned DIV and REM.
// One shift-subtract iteration per clock on operand magnitudes, the sign is
// applied once at the end. Divide-by-zero and signed overflow finish straight
// away without iterating.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int                CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [DATA_W-1:0] ZERO      = '0;
    localparam logic [DATA_W-1:0] ALL_ONES  = '1;
    localparam logic [DATA_W-1:0] MIN_NEG   = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Iteration state: partial quotient shifts left while the dividend bits
    // shift out of its top into the partial remainder.
    logic [CNT_W-1:0]  iter_cnt;
    logic [DATA_W-1:0] quo_p0;
    logic [DATA_W-1:0] rem_p0;
    logic [DATA_W-1:0] dvs_p0;
    logic              is_rem_p0;
    logic              neg_p0;

    // Decode of the request presented in IDLE.
    logic              is_signed_op;
    logic              div_zero;
    logic              signed_ovf;
    logic              special;
    logic [DATA_W-1:0] special_res;
    logic              neg_in;
    logic              accept;
    logic              finish;

    // One iteration step; the shifted value needs one extra bit because it
    // can reach 2*divisor-1 before the compare.
    logic [DATA_W:0]   shifted;
    logic              fits;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] rem_step;
    logic [DATA_W-1:0] quo_step;
    logic [DATA_W-1:0] res_mag;

    // Absolute value; the most negative input maps to 2^(DATA_W-1) as an
    // unsigned pattern, so it never overflows.
    function automatic logic [DATA_W-1:0] magnitude(
        input logic [DATA_W-1:0] x,
        input logic              is_signed
    );
        logic signed [DATA_W-1:0] xs;
        xs = $signed(x);
        if (is_signed && x[DATA_W-1]) begin
            return $unsigned(-xs);
        end
        return x;
    endfunction

    // Two's-complement negation when the result must be negative; negating a
    // zero magnitude gives zero again.
    function automatic logic [DATA_W-1:0] apply_sign(
        input logic [DATA_W-1:0] mag,
        input logic              neg
    );
        logic signed [DATA_W-1:0] ms;
        ms = $signed(mag);
        if (neg) begin
            return $unsigned(-ms);
        end
        return mag;
    endfunction

    // Request decode: special cases and the sign of the eventual result.
    always_comb begin
        is_signed_op = ~op_i[0];
        div_zero     = (src2_i == ZERO);
        signed_ovf   = is_signed_op && (src1_i == MIN_NEG) && (src2_i == ALL_ONES);
        special      = div_zero || signed_ovf;
        if (div_zero) begin
            special_res = op_i[1] ? src1_i : ALL_ONES;
        end else begin
            special_res = op_i[1] ? ZERO : MIN_NEG;
        end
        if (op_i[1]) begin
            neg_in = is_signed_op && src1_i[DATA_W-1];
        end else begin
            neg_in = is_signed_op && (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
        end
        accept = (state == IDLE) && start_i && !flush_i;
        finish = (state == RUN) && !flush_i && (iter_cnt == LAST_ITER);
    end

    // Restoring shift-subtract step on the current partial remainder.
    always_comb begin
        shifted  = {rem_p0, quo_p0[DATA_W-1]};
        fits     = (shifted >= {1'b0, dvs_p0});
        diff     = shifted[DATA_W-1:0] - dvs_p0;
        rem_step = fits ? diff : shifted[DATA_W-1:0];
        quo_step = {quo_p0[DATA_W-2:0], fits};
        res_mag  = is_rem_p0 ? rem_step : quo_step;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: flush wins everywhere, start is only seen in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = special ? DONE : RUN;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (iter_cnt == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Iteration counter: counts edges spent in RUN, zero everywhere else.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iter_cnt <= '0;
        end else if ((state == RUN) && !flush_i) begin
            iter_cnt <= iter_cnt + CNT_ONE;
        end else begin
            iter_cnt <= '0;
        end
    end

    // ---- stage p0: operand capture at acceptance, then one step per RUN edge
    always_ff @(posedge clk_i) begin
        if (accept) begin
            quo_p0    <= magnitude(src1_i, is_signed_op);
            rem_p0    <= ZERO;
            dvs_p0    <= magnitude(src2_i, is_signed_op);
            is_rem_p0 <= op_i[1];
            neg_p0    <= neg_in;
        end else if (state == RUN) begin
            quo_p0    <= quo_step;
            rem_p0    <= rem_step;
        end
    end

    // ---- stage p1: result register, written only on entry to DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= ZERO;
        end else if (accept && special) begin
            data_o <= special_res;
        end else if (finish) begin
            data_o <= apply_sign(res_mag, neg_p0);
        end
    end

    assign busy_o  = (state != IDLE);
    assign valid_o = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with a cycle-level reference
// model and a per-cycle compare of busy_o, valid_o and data_o.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        busy;
    logic        valid;
    logic [31:0] data;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .flush_i (flush),
        .op_i    (op),
        .src1_i  (src1),
        .src2_i  (src2),
        .busy_o  (busy),
        .valid_o (valid),
        .data_o  (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result from plain integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] f_op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        if (b == 32'd0) return f_op[1] ? a : 32'hFFFF_FFFF;
        if (!f_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f_op[1] ? 32'd0 : 32'h8000_0000;
        if (!f_op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        r = f_op[1] ? (sa % sb) : (sa / sb);
        return r[31:0];
    endfunction

    function automatic bit ref_special(input logic [1:0] f_op, input logic [31:0] a,
                                       input logic [31:0] b);
        return (b == 32'd0) || (!f_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Model: m_left = cycles of busy still ahead; valid in the last of them.
    int          m_left = 0;
    logic [31:0] m_data = 32'd0;
    logic [31:0] m_pend = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_data <= 32'd0;
        end else if (m_left > 0) begin
            if (flush) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 2) m_data <= m_pend;
            end
        end else if (start && !flush) begin
            if (ref_special(op, src1, src2)) begin
                m_left <= 1;
                m_data <= ref_result(op, src1, src2);
            end else begin
                m_left <= 33;
                m_pend <= ref_result(op, src1, src2);
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_left > 0));
        check("valid", 32'(valid), 32'(m_left == 1));
        check("data", data, m_data);
    end

    // Present a request for one edge (E0); returns #1 after E0.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called #1 after E0; counts cycles to valid and checks the result.
    task automatic wait_valid(input string name, input logic [31:0] exp, input int lat);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (valid) seen = 1;
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_data"}, data, exp);
            check({name, "_lat"}, 32'(n), 32'(lat));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
        start_op(o, a, b);
        wait_valid(name, exp, lat);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", data, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        run_vec("div_100_7",   OP_DIV,  32'd100,        32'd7, 32'd14,         33);
        run_vec("rem_100_7",   OP_REM,  32'd100,        32'd7, 32'd2,          33);
        run_vec("div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFD,  33);
        run_vec("rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFF,  33);
        run_vec("divu_max_2",  OP_DIVU, 32'hFFFF_FFFF,  32'd2, 32'h7FFF_FFFF,  33);
        run_vec("remu_max_2",  OP_REMU, 32'hFFFF_FFFF,  32'd2, 32'd1,          33);
        run_vec("div_7_m2",    OP_DIV,  32'd7,  32'hFFFF_FFFE, 32'hFFFF_FFFD,  33);
        run_vec("rem_7_m2",    OP_REM,  32'd7,  32'hFFFF_FFFE, 32'd1,          33);
        run_vec("rem_m6_3",    OP_REM,  32'hFFFF_FFFA,  32'd3, 32'd0,          33);
        run_vec("div_0_5",     OP_DIV,  32'd0,          32'd5, 32'd0,          33);
        run_vec("div_min_2",   OP_DIV,  32'h8000_0000,  32'd2, 32'hC000_0000,  33);
        run_vec("divu_min_3",  OP_DIVU, 32'h8000_0000,  32'd3, 32'h2AAA_AAAA,  33);
        run_vec("div_5_0",     OP_DIV,  32'd5,          32'd0, 32'hFFFF_FFFF,  1);
        run_vec("rem_5_0",     OP_REM,  32'd5,          32'd0, 32'd5,          1);
        run_vec("divu_5_0",    OP_DIVU, 32'd5,          32'd0, 32'hFFFF_FFFF,  1);
        run_vec("remu_5_0",    OP_REMU, 32'd5,          32'd0, 32'd5,          1);
        run_vec("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_vec("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // start held high, operands changed mid-run; next op only from IDLE
        start = 1'b1;
        op    = OP_DIV;
        src1  = 32'd100;
        src2  = 32'd7;
        @(posedge clk);
        #1;
        src1 = 32'd50;
        src2 = 32'd3;
        wait_valid("hold_first", 32'd14, 33);
        @(posedge clk);
        #1 start = 1'b0;
        wait_valid("hold_second", 32'd16, 33);

        // flush at iteration 10
        start_op(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_valid", 32'(valid), 32'd0);
        check("flush_data", data, 32'd16);
        repeat (36) @(posedge clk);
        #1 check("flush_data_later", data, 32'd16);

        // flush in IDLE blocks start
        start = 1'b1;
        flush = 1'b1;
        op    = OP_DIVU;
        src1  = 32'd9;
        src2  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("idle_flush_busy", 32'(busy), 32'd0);

        // asynchronous reset mid-run
        start_op(OP_DIV, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_data", data, 32'd0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        run_vec("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
